// File: rtl/sequential_multiplier.sv
// Iterative signed WIDTH x WIDTH multiplier, radix-2 Booth, one multiplier bit per clock.
// Optional build macro SEQ_MULT_ZERO_SKIP_EN: zero operands complete in one cycle without entering BUSY.
module sequential_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done,
    output logic                 active,
    output logic                 o_dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Handshake: start is taken on a rising edge only while IDLE (active=0);
    // A/B are sampled on that edge alone. done is a one-cycle pulse marking a
    // freshly written product; starts seen while BUSY are dropped, not queued.
    state_t               r_state, w_state_next;
    logic [WIDTH:0]       r_mcand, w_mcand_next;
    logic [2*WIDTH+1:0]   r_acc, w_acc_next;
    logic [CW-1:0]        r_count, w_count_next;
    logic [2*WIDTH-1:0]   r_product, w_product_next;
    logic                 r_done, w_done_next;

    logic [WIDTH:0]       w_upper;
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH+1:0]   w_shifted;
    logic                 w_zero;

    // One Booth step: the upper part is WIDTH+1 bits so A = -2^(WIDTH-1) never overflows.
    always_comb begin
        w_upper = r_acc[2*WIDTH+1:WIDTH+1];
        case (r_acc[1:0])
            2'b01:   w_sum = w_upper + r_mcand;
            2'b10:   w_sum = w_upper - r_mcand;
            default: w_sum = w_upper;
        endcase
        w_shifted = {w_sum[WIDTH], w_sum, r_acc[WIDTH:1]};
    end

`ifdef SEQ_MULT_ZERO_SKIP_EN
    assign w_zero = (A == '0) || (B == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_comb begin
        w_state_next   = r_state;
        w_mcand_next   = r_mcand;
        w_acc_next     = r_acc;
        w_count_next   = r_count;
        w_product_next = r_product;
        w_done_next    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (w_zero) begin
                        w_product_next = '0;
                        w_done_next    = 1'b1;
                    end else begin
                        w_state_next = BUSY;
                        w_mcand_next = {A[WIDTH-1], A};
                        w_acc_next   = {{(WIDTH+1){1'b0}}, B, 1'b0};
                        w_count_next = CW'(WIDTH);
                    end
                end
            end
            BUSY: begin
                w_acc_next   = w_shifted;
                w_count_next = r_count - CW'(1);
                // Final step: drop the q(-1) bit and the duplicated top sign bit.
                if (r_count == CW'(1)) begin
                    w_product_next = w_shifted[2*WIDTH:1];
                    w_done_next    = 1'b1;
                    w_state_next   = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_mcand   <= w_mcand_next;
            r_acc     <= w_acc_next;
            r_count   <= w_count_next;
            r_product <= w_product_next;
            r_done    <= w_done_next;
        end
    end

    assign product     = r_product;
    assign done        = r_done;
    assign active      = (r_state == BUSY);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Self-checking bench for sequential_multiplier: scoreboard of expected products, latency and handshake checks.
module tb_sequential_multiplier;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic [2*W-1:0]   product;
    logic             done;
    logic             active;
    logic             dbg_state;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [2*W-1:0]   exp_q[$];

    sequential_multiplier #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (a),
        .B           (b),
        .product     (product),
        .done        (done),
        .active      (active),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    // Scoreboard: every done pulse pops one expected product.
    always @(negedge clk) begin
        if (rst && done === 1'b1) begin
            if (exp_q.size() == 0) check("spurious_done", 64'(done), 64'(0));
            else check("product", product, exp_q.pop_front());
        end
    end

    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic [2*W-1:0] exp, input bit disturb);
        int n;
        int bad_active;
        int exp_n;
        bit seen;
        @(negedge clk);
        a = oa;
        b = ob;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        start = 1'b0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
        exp_n = (oa == '0 || ob == '0) ? 1 : W + 1;
`else
        exp_n = W + 1;
`endif
        n = 0;
        bad_active = 0;
        seen = 1'b0;
        while (!seen && n < W + 5) begin
            @(negedge clk);
            n++;
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
                if (active) bad_active++;
            end else begin
                if (!active) bad_active++;
                if (disturb) begin
                    a = $urandom();
                    b = $urandom();
                    start = 1'($urandom_range(0, 1));
                end
            end
        end
        start = 1'b0;
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(n), 64'(exp_n));
        check("active_window", 64'(bad_active), 64'(0));
        if (!seen) exp_q.delete();
        @(negedge clk);
        check("done_pulse", 64'(done), 64'(0));
    endtask

    task automatic wait_done(output bit seen);
        int n;
        n = 0;
        seen = 1'b0;
        while (!seen && n < W + 5) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
    endtask

    task automatic back_to_back(input logic [W-1:0] a0, input logic [W-1:0] b0,
                                input logic [W-1:0] a1, input logic [W-1:0] b1);
        bit seen;
        @(negedge clk);
        a = a0;
        b = b0;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_mul(a0, b0));
        wait_done(seen);
        check("b2b_first_done", 64'(seen), 64'(1));
        a = a1;
        b = b1;
        @(posedge clk);
        exp_q.push_back(ref_mul(a1, b1));
        #1;
        start = 1'b0;
        @(negedge clk);
        check("b2b_pulse", 64'(done), 64'(0));
        check("b2b_hold", product, ref_mul(a0, b0));
        check("b2b_active", 64'(active), 64'(1));
        wait_done(seen);
        check("b2b_second_done", 64'(seen), 64'(1));
        if (!seen) exp_q.delete();
        @(negedge clk);
        check("b2b_pulse2", 64'(done), 64'(0));
    endtask

    initial begin
        int n_done;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        repeat (3) @(negedge clk);
        check("reset_product", product, 64'(0));
        check("reset_done", 64'(done), 64'(0));
        check("reset_active", 64'(active), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(0));
        rst = 1'b1;

        run_op(32'd10, 32'd20, 64'd200, 1'b0);
        run_op(32'hFFFF_FFF6, 32'd20, 64'hFFFF_FFFF_FFFF_FF38, 1'b0);
        run_op(32'd10, 32'hFFFF_FFEC, 64'hFFFF_FFFF_FFFF_FF38, 1'b0);
        run_op(32'hFFFF_FFF6, 32'hFFFF_FFEC, 64'd200, 1'b0);

        run_op(32'd10, 32'd0, 64'd0, 1'b0);
        run_op(32'd0, 32'd10, 64'd0, 1'b0);

        run_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom();
            rb = $urandom();
            run_op(ra, rb, ref_mul(ra, rb), 1'b1);
        end

        back_to_back(32'd1234, 32'hFFFF_FF00, 32'h8000_0000, 32'd3);
        back_to_back(32'hDEAD_BEEF, 32'h1234_5678, 32'd7, 32'd9);

        run_op(32'd7, 32'd9, 64'd63, 1'b0);
        @(negedge clk);
        a = 32'd5;
        b = 32'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_product", product, 64'(0));
        check("abort_done", 64'(done), 64'(0));
        check("abort_active", 64'(active), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        repeat (W + 5) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 64'(n_done), 64'(0));

        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 9))
                0: ra = 32'h8000_0000;
                1: ra = 32'h7FFF_FFFF;
                default: ra = $urandom();
            endcase
            rb = $urandom();
            run_op(ra, rb, ref_mul(ra, rb), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequential_multiplier.md
Name: sequential_multiplier

Overview:
- Iterative signed two's-complement multiplier: WIDTH x WIDTH -> 2*WIDTH product.
- Computes one multiplier bit per clock using radix-2 Booth recoding.
- Sits beside the ALU datapath as the low-area multiply unit, driven by a start/done handshake.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH. Must be >= 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (0 = reset)
- start  input  1  request pulse; sampled on a rising clk edge while idle
- A  input  WIDTH  signed multiplicand; sampled at the accepting edge only
- B  input  WIDTH  signed multiplier; sampled at the accepting edge only
- product  output  2*WIDTH  signed result; registered and held until the next result is written
- done  output  1  one-cycle pulse: product is valid and newly written
- active  output  1  high while an operation is in progress

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; product=0; done=0; active=0; counter and internal registers cleared.
- Reset mid-operation aborts the operation with no done pulse; product returns to 0.
- States:
  - IDLE: active=0.
  - BUSY: active=1.
  - Transitions: IDLE->BUSY on start=1; BUSY->IDLE after WIDTH iterations.
- Accept edge E0 (IDLE and start=1):
  - Latch A into the multiplicand register, sign-extended to WIDTH+1 bits.
  - Load accumulator with {WIDTH+1 zeros, B, 1'b0}, i.e. Booth bit q(-1)=0.
  - counter=WIDTH; active=1 from after E0.
- Edges E1..E_WIDTH (BUSY), one iteration each, on the pair (q0, q-1):
  - 01: add multiplicand to the upper part.
  - 10: subtract multiplicand from the upper part.
  - 00 or 11: no add/subtract.
  - Then arithmetic-shift the whole register right by 1 and decrement counter.
- Upper part uses WIDTH+1 bits so that A = -2^(WIDTH-1) cannot overflow.
- On edge E_WIDTH:
  - product <= exact signed 2*WIDTH-bit A*B.
  - done <= 1; active <= 0; state <= IDLE.
- Latency: done is high in the cycle after edge E_WIDTH, i.e. WIDTH clocks after the accepting edge (32 for the default).
- done is cleared on the next edge. product stays unchanged until the next completion or reset.
- start while BUSY is ignored; no queuing. A and B changing while BUSY do not affect the result.
- start held high across completion: a new operation is accepted on the edge where done=1, because the state is already IDLE. done still pulses for exactly one cycle.
- Result is exact for all inputs; no overflow is possible. Example: (-2^31)*(-2^31) = 2^62.

Optional Feature:
- Macro: SEQ_MULT_ZERO_SKIP_EN.
- When defined, at the accepting edge, if A==0 or B==0:
  - Skip BUSY; write product=0.
  - Pulse done in the next cycle (latency 1); active stays 0.
- When undefined, zero operands take the full WIDTH-cycle path like any other operand.
- In both builds the product value is identical; only latency differs.

Test Plan:
- Reset behaviour: assert rst=0 mid-operation -> product=0, done=0, active=0 immediately; no done pulse follows release.
- Sign combinations: A=10,B=20 -> 200; A=-10,B=20 -> -200; A=10,B=-20 -> -200; A=-10,B=-20 -> 200. In each case done pulses exactly 32 cycles after the accepting edge, and active is high during those cycles.
- Zero operands: A=10,B=0 -> 0; A=0,B=10 -> 0. Latency is 32 cycles without SEQ_MULT_ZERO_SKIP_EN, 1 cycle with it.
- Extremes:
  - A=B=-2147483648 -> 4611686018427387904.
  - A=2147483647, B=-2147483648 -> -4611686016279904256.
  - A=-1,B=-1 -> 1.
- Random: 1000 random signed pairs -> product equals the 64-bit signed reference model.
- Handshake:
  - Toggle A/B and pulse start while BUSY -> result matches the originally latched operands; no extra done.
  - Hold start high -> back-to-back operations; each done is a 1-cycle pulse, and product holds between completions.
